// File: rtl/pdp_trace_sequencer_if.sv
// Core -> sequencer -> display signal bundle for the PDP-11 trace path.
// PDP_TRACE_STATS_EN adds the per-type record counters.
interface pdp_trace_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             mode;
  logic             ret_valid;
  logic             ret_ready;
  logic [1:0]       ret_type;
  logic             ret_halt;
  logic [6:0]       ret_opid;
  logic [127:0]     ret_regs;
  logic [3:0]       ret_flags;
  logic             disp_valid;
  logic             disp_ready;
  logic [1:0]       disp_type;
  logic             disp_halt;
  logic [6:0]       disp_opid;
  logic [3:0]       disp_flags;
  logic [127:0]     disp_regs;
  logic [CNT_W-1:0] disp_seq;
  logic [CNT_W-1:0] num_instr;
  logic             sim_done;
  logic             bad_type;
`ifdef PDP_TRACE_STATS_EN
  logic [CNT_W-1:0] cnt_double;
  logic [CNT_W-1:0] cnt_single;
  logic [CNT_W-1:0] cnt_branch;
`endif

  modport slave (
    input  mode, ret_valid, ret_type, ret_halt, ret_opid, ret_regs, ret_flags, disp_ready,
`ifdef PDP_TRACE_STATS_EN
    output cnt_double, cnt_single, cnt_branch,
`endif
    output ret_ready, disp_valid, disp_type, disp_halt, disp_opid, disp_flags, disp_regs,
    output disp_seq, num_instr, sim_done, bad_type
  );

  modport master (
    output mode, ret_valid, ret_type, ret_halt, ret_opid, ret_regs, ret_flags, disp_ready,
`ifdef PDP_TRACE_STATS_EN
    input  cnt_double, cnt_single, cnt_branch,
`endif
    input  ret_ready, disp_valid, disp_type, disp_halt, disp_opid, disp_flags, disp_regs,
    input  disp_seq, num_instr, sim_done, bad_type
  );
endinterface

// File: rtl/pdp_trace_sequencer.sv
// Buffers retired-instruction trace records and presents them to the display stage.
// Optional PDP_TRACE_STATS_EN builds per-type counters of accepted non-HALT records.
//
// state     | meaning
// S_IDLE    | nothing presented; pop head (discard or present)
// S_PRESENT | record held on disp_* until disp_ready
// S_DONE    | HALT delivered; terminal until reset
module pdp_trace_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  reset_n,
  pdp_trace_sequencer_if.slave bus
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0]       typ;
    logic             halt;
    logic [6:0]       opid;
    logic [3:0]       flags;
    logic [127:0]     regs;
    logic [CNT_W-1:0] seq;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRESENT = 2'd1, S_DONE = 2'd2} state_t;

  rec_t             r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  state_t           r_state;
  logic             r_ret_ready, r_halt_seen, r_sim_done, r_bad_type;
  logic [CNT_W-1:0] r_num_instr;
  logic             r_disp_valid, r_disp_halt;
  logic [1:0]       r_disp_type;
  logic [6:0]       r_disp_opid;
  logic [3:0]       r_disp_flags;
  logic [127:0]     r_disp_regs;
  logic [CNT_W-1:0] r_disp_seq;

  rec_t             w_head;
  logic             w_push, w_pop, w_ack, w_show, w_halt_nxt, w_done_nxt;
  logic [AW:0]      w_count_nxt;
  logic [15:0]      w_pc;
  logic [CNT_W-1:0] w_seq;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_push      = bus.ret_valid && r_ret_ready;
  assign w_ack       = (r_state == S_PRESENT) && bus.disp_ready;
  assign w_show      = bus.mode || w_head.halt;
  // Head leaves the FIFO whenever IDLE, or on a non-HALT ack (back-to-back)
  assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || (w_ack && !r_disp_halt));
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_halt_nxt  = r_halt_seen || (w_push && bus.ret_halt);
  assign w_done_nxt  = r_sim_done || (w_ack && r_disp_halt);
  assign w_pc        = w_head.halt ? w_head.regs[127:112] : w_head.regs[127:112] - 16'd2;
  assign w_seq       = r_num_instr + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {bus.ret_type, bus.ret_halt, bus.ret_opid, bus.ret_flags, bus.ret_regs, w_seq};
  end

`ifdef PDP_TRACE_STATS_EN
  logic [CNT_W-1:0] r_cnt_double, r_cnt_single, r_cnt_branch;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt_double <= '0;
      r_cnt_single <= '0;
      r_cnt_branch <= '0;
    end else if (w_push && !bus.ret_halt) begin
      case (bus.ret_type)
        2'd0:    r_cnt_double <= r_cnt_double + CNT_W'(1);
        2'd1:    r_cnt_single <= r_cnt_single + CNT_W'(1);
        2'd2:    r_cnt_branch <= r_cnt_branch + CNT_W'(1);
        default: ;
      endcase
    end
  end
  assign bus.cnt_double = r_cnt_double;
  assign bus.cnt_single = r_cnt_single;
  assign bus.cnt_branch = r_cnt_branch;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_state      <= S_IDLE;
      r_ret_ready  <= 1'b0;
      r_halt_seen  <= 1'b0;
      r_sim_done   <= 1'b0;
      r_bad_type   <= 1'b0;
      r_num_instr  <= '0;
      r_disp_valid <= 1'b0;
      r_disp_halt  <= 1'b0;
      r_disp_type  <= '0;
      r_disp_opid  <= '0;
      r_disp_flags <= '0;
      r_disp_regs  <= '0;
      r_disp_seq   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_num_instr <= w_seq;
        if (bus.ret_type == 2'd3) r_bad_type <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_nxt;
      r_halt_seen <= w_halt_nxt;
      // Registered ready: look ahead at next occupancy so a full FIFO is never pushed
      r_ret_ready <= (w_count_nxt != LP_FULL) && !w_halt_nxt && !w_done_nxt;

      case (r_state)
        S_IDLE: begin
          if (w_pop && w_show) begin
            r_disp_valid <= 1'b1;
            r_disp_type  <= w_head.typ;
            r_disp_halt  <= w_head.halt;
            r_disp_opid  <= w_head.opid;
            r_disp_flags <= w_head.flags;
            r_disp_regs  <= {w_pc, w_head.regs[111:0]};
            r_disp_seq   <= w_head.seq;
            r_state      <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (w_ack) begin
            if (r_disp_halt) begin
              r_disp_valid <= 1'b0;
              r_sim_done   <= 1'b1;
              r_state      <= S_DONE;
            end else if (w_pop && w_show) begin
              r_disp_type  <= w_head.typ;
              r_disp_halt  <= w_head.halt;
              r_disp_opid  <= w_head.opid;
              r_disp_flags <= w_head.flags;
              r_disp_regs  <= {w_pc, w_head.regs[111:0]};
              r_disp_seq   <= w_head.seq;
            end else begin
              r_disp_valid <= 1'b0;
              r_state      <= S_IDLE;
            end
          end
        end
        default: r_disp_valid <= 1'b0;
      endcase
    end
  end

  assign bus.ret_ready  = r_ret_ready;
  assign bus.disp_valid = r_disp_valid;
  assign bus.disp_type  = r_disp_type;
  assign bus.disp_halt  = r_disp_halt;
  assign bus.disp_opid  = r_disp_opid;
  assign bus.disp_flags = r_disp_flags;
  assign bus.disp_regs  = r_disp_regs;
  assign bus.disp_seq   = r_disp_seq;
  assign bus.num_instr  = r_num_instr;
  assign bus.sim_done   = r_sim_done;
  assign bus.bad_type   = r_bad_type;
endmodule
